// File: rtl/compare_pulse_gen.sv
// Output-compare pulse generator: after a loaded delay C, drives one gate pulse of width max(W,1).
// Optional periodic mode: define COMPARE_PULSE_GEN_AUTO_RELOAD_EN to re-enter DELAY from DONE.
module compare_pulse_gen #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             timer_enable,
    input  logic             load,
    input  logic [WIDTH-1:0] compare_value,
    input  logic [WIDTH-1:0] pulse_width,
    output logic [WIDTH-1:0] counter,
    output logic [2:0]       state,
    output logic             gate_out,
    output logic             compare_complete
);

    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        ARMED = 3'b001,
        DELAY = 3'b010,
        PULSE = 3'b011,
        DONE  = 3'b100
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] cmp_q;
    logic [WIDTH-1:0] width_q;
    logic [WIDTH-1:0] counter_d;
    logic             complete_d;
    logic             delay_hit;
    logic             pulse_hit;

    assign delay_hit = (counter == cmp_q);
    assign pulse_hit = (counter == width_q - 1'b1);
    assign state     = state_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load) state_d = ARMED;
            ARMED:   if (timer_enable) state_d = DELAY;
            DELAY:   if (timer_enable && delay_hit) state_d = PULSE;
            PULSE: begin
                if (!timer_enable)  state_d = IDLE;
                else if (pulse_hit) state_d = DONE;
            end
            DONE: begin
`ifdef COMPARE_PULSE_GEN_AUTO_RELOAD_EN
                state_d = timer_enable ? DELAY : IDLE;
`else
                if (!timer_enable) state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        counter_d  = '0;
        complete_d = 1'b0;
        gate_out   = (state_q == PULSE);
        case (state_q)
            DELAY: begin
                if (!timer_enable)  counter_d = counter;
                else if (delay_hit) counter_d = '0;
                else                counter_d = counter + 1'b1;
            end
            PULSE: begin
                if (timer_enable) begin
                    if (pulse_hit) begin
                        counter_d  = counter;
                        complete_d = 1'b1;
                    end else begin
                        counter_d = counter + 1'b1;
                    end
                end
            end
            // Counter holds while parked in DONE; leaving DONE always restarts from zero.
            DONE:    counter_d = (state_d == DONE) ? counter : '0;
            default: counter_d = '0;
        endcase
    end

    // Compare/width latches are only written in IDLE, so a run never sees them change.
    always_ff @(posedge clk) begin
        if (reset) begin
            counter          <= '0;
            compare_complete <= 1'b0;
            cmp_q            <= '0;
            width_q          <= '0;
        end else begin
            counter          <= counter_d;
            compare_complete <= complete_d;
            if (state_q == IDLE && load) begin
                cmp_q   <= compare_value;
                width_q <= (pulse_width == '0) ? WIDTH'(1) : pulse_width;
            end
        end
    end

endmodule

// File: doc/compare_pulse_gen.md
# compare_pulse_gen

Output-compare pulse generator for the lab2 capture-timer path; the transmit-side counterpart of the capture counter. It is loaded with a delay and a width. Once enabled, it counts the delay and then drives a single gate pulse of exact width on `gate_out`. That output feeds a capture counter's `capture_gate`, so the measured count can be checked against a known stimulus.

## Interface
- `WIDTH`, default 32: width of counter, compare and width registers.

- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high; wins over every other input.
- `timer_enable` in 1: run/abort control.
- `load` in 1: level; sampled only in IDLE; latches `compare_value` and `pulse_width`.
- `compare_value` in WIDTH: delay count C.
- `pulse_width` in WIDTH: pulse length W; 0 is treated as 1.
- `counter` out WIDTH: live phase counter.
- `state` out 3: current FSM state.
- `gate_out` out 1: generated pulse; decoded from the state register, high iff state == PULSE.
- `compare_complete` out 1: one-cycle strobe at pulse end.

## Operation
States and encodings:
- IDLE 3'b000
- ARMED 3'b001
- DELAY 3'b010
- PULSE 3'b011
- DONE 3'b100
- Unused codes go to IDLE next edge.

Transitions and per-state behaviour:
- **IDLE:** `counter` = 0. On `load`=1: latch C and W (W=0 stored as 1), then go to ARMED.
- **ARMED:** `counter` = 0; `load` ignored. On `timer_enable`=1: go to DELAY with `counter` = 0.
- **DELAY:**
  - With `timer_enable`=1: if `counter` == C, go to PULSE with `counter` <= 0; else `counter` +1.
  - With `timer_enable`=0: `counter` holds (pause); stays in DELAY.
- **PULSE:**
  - With `timer_enable`=1: if `counter` == W-1, go to DONE with `compare_complete` <= 1 and `counter` holding; else `counter` +1.
  - With `timer_enable`=0: abort to IDLE, `counter` <= 0, no `compare_complete`.
- **DONE:**
  - `compare_complete` is high only for the first cycle in DONE.
  - Goes to IDLE when `timer_enable`=0. See Configuration for `timer_enable`=1.

General rules:
- `load` outside IDLE is ignored; the latched C and W are never modified mid-run.
- Arithmetic is unsigned. `counter` never exceeds max(C, W-1), so there is no wrap-around. C = 2^WIDTH-1 is legal.
- Reset mid-operation: next edge gives state IDLE, `counter` 0, `gate_out` 0, `compare_complete` 0, latched C/W 0.

## Timing
- Reset values: `counter` 0, `state` 3'b000, `gate_out` 0, `compare_complete` 0.
- ARMED→DELAY: one edge after `timer_enable` is sampled high.
- DELAY lasts C+1 enabled cycles (`counter` 0..C). `gate_out` rises on the edge after the cycle where `counter` == C.
- `gate_out` is high for exactly max(W,1) cycles. `compare_complete` rises on the same edge at which `gate_out` falls.
- Total from first DELAY cycle to `gate_out` rise: C+1 cycles, with no pause.
- `load` and `timer_enable` sampled high in the same IDLE cycle: only the load is taken. DELAY starts one cycle after ARMED is entered.

## Configuration
- `COMPARE_PULSE_GEN_AUTO_RELOAD_EN` defined:
  - DONE with `timer_enable`=1 returns to DELAY after one cycle, with `counter` 0.
  - This gives a periodic gate with period C+1+W+1 cycles.
  - `compare_complete` strobes once per period.
- Not defined: DONE holds, with `gate_out` 0, until `timer_enable`=0, then goes to IDLE. The generator is single-shot.

## Test plan
- **Reset:** `reset`=1 for 2 cycles with random inputs -> `state` 000, `counter` 0, `gate_out` 0, `compare_complete` 0.
- **Basic shot:** load C=5, W=3, then `timer_enable`=1 -> `gate_out` high exactly 3 cycles, beginning 6 cycles after DELAY entry. `compare_complete` is a single cycle on the falling edge of `gate_out`. Drop `timer_enable` -> IDLE.
- **Pause and abort:**
  - C=10, W=4; deassert `timer_enable` for 5 cycles at `counter`=4 -> `counter` holds at 4; the gate rises 5 cycles later than unpaused.
  - Second run: deassert during PULSE -> IDLE, `gate_out` 0, no `compare_complete`.
- **Boundaries:**
  - C=0, W=0 -> `gate_out` high for 1 cycle, 1 cycle after DELAY entry.
  - `load` with C=7 during DELAY -> ignored; the original C still governs.
- **Loopback:** `gate_out` connected to a capture counter's `capture_gate`, C=20, W=50 -> captured width equals 50 cycles.
- **Auto-reload (macro defined):** C=2, W=2, `timer_enable` held -> `gate_out` period 6 cycles; 3 consecutive `compare_complete` strobes 6 cycles apart. Reset asserted mid-PULSE -> IDLE on the next edge.
